load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/load_store_unit_load_extend.sv | 37 +++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the L1 data-cache initiator: cache operations, FSM states
// and the alignment helpers used to decide whether a request is split into byte beats.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        mem_idle  = 4'd0,
        ld_byte_s = 4'd1,
        ld_byte_u = 4'd2,
        ld_half_s = 4'd3,
        ld_half_u = 4'd4,
        ld_word   = 4'd5,
        str_byte  = 4'd6,
        str_half  = 4'd7,
        str_word  = 4'd8
    } mem_operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input mem_operation_t op);
        return (op == ld_byte_s) || (op == ld_byte_u) || (op == ld_half_s) ||
               (op == ld_half_u) || (op == ld_word);
    endfunction

    function automatic logic is_half(input mem_operation_t op);
        return (op == ld_half_s) || (op == ld_half_u) || (op == str_half);
    endfunction

    function automatic logic is_misaligned(input mem_operation_t op, input logic [1:0] lo);
        logic mis;
        case (op)
            ld_half_s, ld_half_u, str_half: mis = lo[0];
            ld_word, str_word:              mis = (lo != 2'b00);
            default:                        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Byte/half-word select with sign or zero extension; purely combinational.
// Misaligned halves come pre-assembled in bytes 0..1, aligned ones are picked by lane.
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int WORD_LENGTH = 4
) (
    input  mem_operation_t               op_i,
    input  logic [1:0]                   lane_i,
    input  logic                         misaligned_i,
    input  logic [WORD_LENGTH*8-1:0]     data_i,
    output logic [WORD_LENGTH*8-1:0]     data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[{lane_i, 3'b000} +: 8];
        if (misaligned_i || !lane_i[1]) begin
            half_sel = data_i[15:0];
        end else begin
            half_sel = data_i[31:16];
        end

        data_o = '0;
        case (op_i)
            ld_byte_s: data_o = {{24{byte_sel[7]}}, byte_sel};
            ld_byte_u: data_o = {24'h0, byte_sel};
            ld_half_s: data_o = {{16{half_sel[15]}}, half_sel};
            ld_half_u: data_o = {16'h0, half_sel};
            ld_word:   data_o = data_i;
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the L1 data cache: one request at a time, first access issued
// combinationally on accept, misaligned half/word accesses split into sequential byte beats.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_LENGTH   = 4,
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  mem_operation_t               req_op,
    input  logic [ADDRESS_WIDTH-1:0]     req_addr,
    input  logic [WORD_LENGTH*8-1:0]     req_wdata,
    output logic                         resp_valid,
    output logic [WORD_LENGTH*8-1:0]     resp_rdata,
    output logic                         resp_misaligned,
    output logic                         stall,
    output mem_operation_t               cache_op,
    output logic [ADDRESS_WIDTH-1:0]     cache_addr,
    output logic [WORD_LENGTH*8-1:0]     cache_wdata,
    input  logic [WORD_LENGTH*8-1:0]     cache_rdata
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = WORD_LENGTH * 8;

    lsu_state_t     state_q, state_d;
    mem_operation_t op_q, op_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  data_q, data_d;
    logic [1:0]     beat_q, beat_d;
    logic [1:0]     last_q, last_d;
    logic           mis_q, mis_d;

    logic [AW-1:0]  beat_addr;
    logic [DW-1:0]  ext_data;

    // Wraps naturally at the top of the address space.
    assign beat_addr = addr_q + AW'(beat_q);

    load_extend #(.WORD_LENGTH(WORD_LENGTH)) u_load_extend (
        .op_i         (op_q),
        .lane_i       (addr_q[1:0]),
        .misaligned_i (mis_q),
        .data_i       (data_q),
        .data_o       (ext_data)
    );

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        data_d          = data_q;
        beat_d          = beat_q;
        last_d          = last_q;
        mis_d           = mis_q;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_misaligned = 1'b0;
        cache_op        = mem_idle;
        cache_addr      = '0;
        cache_wdata     = '0;
        stall           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_op != mem_idle)) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    beat_d  = 2'd1;
                    last_d  = is_half(req_op) ? 2'd1 : 2'd3;
                    mis_d   = is_misaligned(req_op, req_addr[1:0]);
                    if (mis_d) begin
                        state_d = BEAT;
                        if (is_load(req_op)) begin
                            cache_op    = ld_word;
                            cache_addr  = {req_addr[AW-1:2], 2'b00};
                            data_d      = '0;
                            data_d[7:0] = cache_rdata[{req_addr[1:0], 3'b000} +: 8];
                        end else begin
                            cache_op         = str_byte;
                            cache_addr       = req_addr;
                            cache_wdata[7:0] = req_wdata[7:0];
                        end
                    end else begin
                        state_d = RESP;
                        if (is_load(req_op)) begin
                            // Loads always fetch the whole word; extraction happens locally.
                            cache_op   = ld_word;
                            cache_addr = {req_addr[AW-1:2], 2'b00};
                            data_d     = cache_rdata;
                        end else begin
                            cache_op    = req_op;
                            cache_addr  = req_addr;
                            cache_wdata = req_wdata;
                        end
                    end
                end
            end
            BEAT: begin
                if (is_load(op_q)) begin
                    cache_op   = ld_word;
                    cache_addr = {beat_addr[AW-1:2], 2'b00};
                    data_d[{beat_q, 3'b000} +: 8] = cache_rdata[{beat_addr[1:0], 3'b000} +: 8];
                end else begin
                    cache_op         = str_byte;
                    cache_addr       = beat_addr;
                    cache_wdata[7:0] = wdata_q[{beat_q, 3'b000} +: 8];
                end
                if (beat_q == last_q) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            RESP: begin
                resp_valid      = 1'b1;
                resp_misaligned = mis_q;
                resp_rdata      = is_load(op_q) ? ext_data : '0;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            op_q    <= mem_idle;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: byte-addressed cache model, scoreboard queues for cache accesses
// and responses, checked by a negedge monitor independent of the stimulus.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic           clk;
    logic           rstN;
    logic           req_valid;
    logic           req_ready;
    mem_operation_t req_op;
    logic [13:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_misaligned;
    logic           stall;
    mem_operation_t cache_op;
    logic [13:0]    cache_addr;
    logic [31:0]    cache_wdata;
    logic [31:0]    cache_rdata;

    typedef struct {
        mem_operation_t op;
        logic [13:0]    addr;
        logic [31:0]    wdata;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   passed = 0;

    logic [7:0]  mem [0:16383];
    logic [13:0] rd_wa;

    load_store_unit #(.WORD_LENGTH(4), .ADDRESS_WIDTH(14)) dut (
        .clk             (clk),
        .rstN            (rstN),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .stall           (stall),
        .cache_op        (cache_op),
        .cache_addr      (cache_addr),
        .cache_wdata     (cache_wdata),
        .cache_rdata     (cache_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Cache model: ld_word returns the word containing the address; stores land at the edge.
    assign rd_wa = {cache_addr[13:2], 2'b00};
    always_comb begin
        cache_rdata = {mem[rd_wa + 14'd3], mem[rd_wa + 14'd2], mem[rd_wa + 14'd1], mem[rd_wa]};
    end

    initial begin
        logic [13:0] a;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h3FFF] = 8'hA5;
        mem[14'h0000] = 8'h5A;
        forever begin
            @(posedge clk);
            if (rstN) begin
                a = cache_addr;
                case (cache_op)
                    str_byte: mem[a] = cache_wdata[7:0];
                    str_half: begin
                        mem[a] = cache_wdata[7:0];
                        mem[a + 14'd1] = cache_wdata[15:8];
                    end
                    str_word: begin
                        for (int k = 0; k < 4; k++) mem[a + 14'(k)] = cache_wdata[8*k +: 8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: every issued cache access and every response must match the next expectation.
    always @(negedge clk) begin
        if (rstN) begin
            if (cache_op != mem_idle) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_cache_access", 32'(cache_op), 32'(mem_idle));
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("cache_op", 32'(cache_op), 32'(e.op));
                    chk("cache_addr", 32'(cache_addr), 32'(e.addr));
                    if (!is_load(e.op)) chk("cache_wdata", cache_wdata, e.wdata);
                end
            end
            if (resp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_misaligned", 32'(resp_misaligned), 32'(r.mis));
                end
            end
        end
    end

    task automatic exp_acc(input mem_operation_t op, input logic [13:0] addr, input logic [31:0] wd);
        acc_t e;
        e.op = op; e.addr = addr; e.wdata = wd;
        acc_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [31:0] rd, input logic mis);
        rsp_t r;
        r.rdata = rd; r.mis = mis;
        rsp_q.push_back(r);
    endtask

    task automatic do_req(input string name, input mem_operation_t op, input logic [13:0] addr,
                          input logic [31:0] wd, input int exp_cycles);
        int cyc;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = mem_idle;
        cyc = 1;
        while (stall && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rstN = 1'b0; req_valid = 1'b0; req_op = mem_idle; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_mis", 32'(resp_misaligned), 32'd0);
        chk("rst_cache_op", 32'(cache_op), 32'(mem_idle));
        chk("rst_cache_addr", 32'(cache_addr), 32'd0);
        chk("rst_cache_wdata", cache_wdata, 32'd0);
        @(posedge clk); #1 rstN = 1'b1;

        exp_acc(str_word, 14'h010, 32'hDEADBEEF); exp_rsp(32'h0, 1'b0);
        do_req("st_word", str_word, 14'h010, 32'hDEADBEEF, 2);
        exp_acc(ld_word, 14'h010, 32'h0); exp_rsp(32'hDEADBEEF, 1'b0);
        do_req("ld_word", ld_word, 14'h010, 32'h0, 2);
        exp_acc(ld_word, 14'h010, 32'h0); exp_rsp(32'hFFFFFFDE, 1'b0);
        do_req("ld_byte_s", ld_byte_s, 14'h013, 32'h0, 2);
        exp_acc(ld_word, 14'h010, 32'h0); exp_rsp(32'h000000DE, 1'b0);
        do_req("ld_byte_u", ld_byte_u, 14'h013, 32'h0, 2);
        exp_acc(ld_word, 14'h010, 32'h0); exp_rsp(32'hFFFFDEAD, 1'b0);
        do_req("ld_half_s", ld_half_s, 14'h012, 32'h0, 2);
        exp_acc(ld_word, 14'h010, 32'h0); exp_rsp(32'h0000BEEF, 1'b0);
        do_req("ld_half_u", ld_half_u, 14'h010, 32'h0, 2);

        exp_acc(str_byte, 14'h00E, 32'h44); exp_acc(str_byte, 14'h00F, 32'h33);
        exp_acc(str_byte, 14'h010, 32'h22); exp_acc(str_byte, 14'h011, 32'h11);
        exp_rsp(32'h0, 1'b1);
        do_req("mis_st_word", str_word, 14'h00E, 32'h11223344, 5);
        exp_acc(ld_word, 14'h00C, 32'h0); exp_acc(ld_word, 14'h00C, 32'h0);
        exp_acc(ld_word, 14'h010, 32'h0); exp_acc(ld_word, 14'h010, 32'h0);
        exp_rsp(32'h11223344, 1'b1);
        do_req("mis_ld_word", ld_word, 14'h00E, 32'h0, 5);

        exp_acc(ld_word, 14'h3FFC, 32'h0); exp_acc(ld_word, 14'h0000, 32'h0);
        exp_rsp(32'h00005AA5, 1'b1);
        do_req("wrap_ld_half", ld_half_u, 14'h3FFF, 32'h0, 3);

        // Reset lands while beat 2 of a split store is on the cache port.
        exp_acc(str_byte, 14'h021, 32'h0D); exp_acc(str_byte, 14'h022, 32'hF0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = str_word; req_addr = 14'h021; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = mem_idle;
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        chk("arst_cache_op", 32'(cache_op), 32'(mem_idle));
        chk("arst_cache_addr", 32'(cache_addr), 32'd0);
        chk("arst_cache_wdata", cache_wdata, 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (3) @(posedge clk);
        chk("arst_pending_acc", 32'(acc_q.size()), 32'd0);

        exp_acc(ld_word, 14'h020, 32'h0); exp_rsp(32'h00F00D00, 1'b0);
        do_req("arst_readback", ld_word, 14'h020, 32'h0, 2);
        exp_acc(ld_word, 14'h024, 32'h0); exp_rsp(32'h00000000, 1'b0);
        do_req("arst_byte3", ld_byte_u, 14'h024, 32'h0, 2);

        @(posedge clk); #1;
        req_valid = 1'b1; req_op = mem_idle; req_addr = 14'h010; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_op_stall", 32'(stall), 32'd0);
            chk("idle_op_cache_op", 32'(cache_op), 32'(mem_idle));
            chk("idle_op_ready", 32'(req_ready), 32'd1);
            chk("idle_op_resp", 32'(resp_valid), 32'd0);
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_acc_queue", 32'(acc_q.size()), 32'd0);
        chk("final_rsp_queue", 32'(rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
